sram_fifo_ctrl_1w1r: RTL

Single-clock FIFO controller that sits directly upstream of the 1W1R OpenRAM macro (256 words × 4 bits) and drives both of its ports. It turns the macro into a valid/ready streaming FIFO. It owns the write/read pointers, the occupancy accounting and the read-data capture. A 2-entry output prefetch buffer absorbs the macro's one-cycle read latency, so the FIFO sustains one push and one pop per cycle.

---
 rtl/sram_fifo_ctrl_1w1r_if.sv | 34 +++
 rtl/sram_fifo_ctrl_1w1r.sv | 81 ++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl_1w1r_if.sv
// sram_fifo_ctrl_1w1r_if: stream handshakes plus both SRAM macro ports of the FIFO controller.
// slave is the controller side; master is the producer/consumer/macro side.
interface sram_fifo_ctrl_1w1r_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH:0]   level;
    logic                  sram_csb0;
    logic [NUM_WMASKS-1:0] sram_wmask0;
    logic [ADDR_WIDTH-1:0] sram_addr0;
    logic [DATA_WIDTH-1:0] sram_din0;
    logic                  sram_csb1;
    logic [ADDR_WIDTH-1:0] sram_addr1;
    logic [DATA_WIDTH-1:0] sram_dout1;

    modport slave (
        input  in_valid, in_data, out_ready, sram_dout1,
        output in_ready, out_valid, out_data, level,
               sram_csb0, sram_wmask0, sram_addr0, sram_din0, sram_csb1, sram_addr1
    );

    modport master (
        output in_valid, in_data, out_ready, sram_dout1,
        input  in_ready, out_valid, out_data, level,
               sram_csb0, sram_wmask0, sram_addr0, sram_din0, sram_csb1, sram_addr1
    );
endinterface

// File: rtl/sram_fifo_ctrl_1w1r.sv
// sram_fifo_ctrl_1w1r: valid/ready FIFO around a 1W1R SRAM macro with a 2-entry read prefetch buffer.
// Define SRAM_FIFO_BYPASS_EN to let a push into an idle FIFO skip the SRAM.
module sram_fifo_ctrl_1w1r #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4
) (
    input logic clk,
    input logic rstb,
    sram_fifo_ctrl_1w1r_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, addr0_q, addr0_d;
    logic [ADDR_WIDTH:0]   sram_cnt_q, sram_cnt_d;
    logic [DATA_WIDTH-1:0] obuf0_q, obuf0_d, obuf1_q, obuf1_d, din0_q, din0_d, fill_data;
    logic [1:0]            obuf_cnt_q, obuf_cnt_d, obuf_rem;
    logic [2:0]            occ;
    logic                  rd_inflight_q, rd_inflight_d;
    logic                  push_fire, pop_fire, bypass, wr_en, rd_en, fill;

    always_comb begin
        push_fire = rstb && bus.in_valid && sram_cnt_q != FULL;
        pop_fire = bus.out_ready && obuf_cnt_q != 2'd0;
        obuf_rem = obuf_cnt_q - {1'b0, pop_fire};
        occ = {1'b0, obuf_cnt_q} + {2'b0, rd_inflight_q} - {2'b0, pop_fire};
`ifdef SRAM_FIFO_BYPASS_EN
        bypass = push_fire && sram_cnt_q == '0 && !rd_inflight_q && obuf_rem < 2'd2;
`else
        bypass = 1'b0;
`endif
        wr_en = push_fire && !bypass;
        rd_en = rstb && sram_cnt_q != '0 && occ < 3'd2;
        // A returning read and a bypass never coincide, so one fill slot suffices
        fill = rd_inflight_q || bypass;
        fill_data = rd_inflight_q ? bus.sram_dout1 : bus.in_data;
        obuf0_d = (fill && obuf_rem == 2'd0) ? fill_data : pop_fire ? obuf1_q : obuf0_q;
        obuf1_d = (fill && obuf_rem == 2'd1) ? fill_data : obuf1_q;
        obuf_cnt_d = obuf_rem + {1'b0, fill};
        sram_cnt_d = sram_cnt_q + {{ADDR_WIDTH{1'b0}}, wr_en} - {{ADDR_WIDTH{1'b0}}, rd_en};
        wr_ptr_d = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, rd_en};
        rd_inflight_d = rd_en;
        addr0_d = wr_en ? wr_ptr_q : addr0_q;
        din0_d = wr_en ? bus.in_data : din0_q;
        bus.in_ready = rstb && sram_cnt_q != FULL;
        bus.out_valid = obuf_cnt_q != 2'd0;
        bus.out_data = obuf0_q;
        bus.level = sram_cnt_q + {{ADDR_WIDTH{1'b0}}, rd_inflight_q} + {{(ADDR_WIDTH-1){1'b0}}, obuf_cnt_q};
        bus.sram_csb0 = !wr_en;
        bus.sram_wmask0 = {NUM_WMASKS{1'b1}};
        bus.sram_addr0 = addr0_d;
        bus.sram_din0 = din0_d;
        bus.sram_csb1 = !rd_en;
        bus.sram_addr1 = rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sram_cnt_q <= '0;
            rd_inflight_q <= 1'b0;
            obuf_cnt_q <= '0;
            obuf0_q <= '0;
            obuf1_q <= '0;
            addr0_q <= '0;
            din0_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sram_cnt_q <= sram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            obuf_cnt_q <= obuf_cnt_d;
            obuf0_q <= obuf0_d;
            obuf1_q <= obuf1_d;
            addr0_q <= addr0_d;
            din0_q <= din0_d;
        end
    end
endmodule
